// File: rtl/adc_spi_master.sv
// rtl/adc_spi_master.sv - SPI master that reads 12-bit conversions from a MAX11131-style ADC
//
// Generates nCS and a divided, registered SCLK, shifts DOUT in MSB first and
// presents each conversion as a parallel word with a valid/ready handshake.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-high reset
//   EN           1 = convert continuously, 0 = finish current frame then idle
//   nCS          ADC chip select (active low), falling edge samples the input
//   SCLK         ADC serial clock, idles high
//   DOUT         ADC serial data, changes on SCLK falling edge
//   sample       last received 12-bit conversion
//   sample_valid sample holds an unconsumed result
//   sample_ready consumer accepts sample when sample_valid && sample_ready
//   overrun      sticky, an unconsumed result was overwritten
//   frame_err    one-cycle pulse, framing zeros violated in the last frame
//   busy         high whenever the controller is not idle
module adc_spi_master #(
  parameter int CLK_DIV    = 2,   // CLK cycles per SCLK half-period, 2..255
  parameter int FRAME_BITS = 16   // SCLK cycles per frame, fixed at 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  output logic        nCS,
  output logic        SCLK,
  input  logic        DOUT,
  output logic [11:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] K_LAST   = 5'(FRAME_BITS);
  localparam logic [4:0] K_CS_UP  = 5'd14;

  state_t      state, state_d;
  logic [7:0]  div_cnt, div_d;
  logic [4:0]  bit_cnt, k_d;
  logic        sclk_d, ncs_d;
  logic        capture;
  logic        div_last;
  // shreg[14] = leading zero, [13:2] = D11..D0, [1:0] = trailing zeros
  logic [14:0] shreg;

  always_comb begin
    state_d  = state;
    div_d    = div_cnt;
    k_d      = bit_cnt;
    sclk_d   = SCLK;
    ncs_d    = nCS;
    capture  = 1'b0;
    div_last = (div_cnt == DIV_LAST);
    case (state)
      ST_IDLE: begin
        ncs_d  = 1'b1;
        sclk_d = 1'b1;
        div_d  = 8'd0;
        k_d    = 5'd0;
        if (EN) begin
          state_d = ST_CS_SETUP;
          ncs_d   = 1'b0;
        end
      end
      ST_CS_SETUP: begin
        if (div_last) begin
          state_d = ST_SHIFT;
          div_d   = 8'd0;
          k_d     = 5'd1;
          sclk_d  = 1'b0;
        end else begin
          div_d = div_cnt + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (!div_last) begin
          div_d = div_cnt + 8'd1;
        end else begin
          div_d = 8'd0;
          if (!SCLK) begin
            // End of low phase: rising SCLK edge samples DOUT. Bit 16 is
            // high-Z on the ADC side and is never captured.
            sclk_d  = 1'b1;
            capture = (bit_cnt != K_LAST);
            if (bit_cnt == K_CS_UP) ncs_d = 1'b1;
          end else if (bit_cnt == K_LAST) begin
            state_d = ST_DONE;
            k_d     = 5'd0;
          end else begin
            sclk_d = 1'b0;
            k_d    = bit_cnt + 5'd1;
          end
        end
      end
      ST_DONE: begin
        ncs_d  = 1'b1;
        sclk_d = 1'b1;
        if (EN) begin
          state_d = ST_CS_SETUP;
          ncs_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      div_cnt      <= 8'd0;
      bit_cnt      <= 5'd0;
      nCS          <= 1'b1;
      SCLK         <= 1'b1;
      shreg        <= 15'd0;
      sample       <= 12'd0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state     <= state_d;
      div_cnt   <= div_d;
      bit_cnt   <= k_d;
      nCS       <= ncs_d;
      SCLK      <= sclk_d;
      busy      <= (state_d != ST_IDLE);
      frame_err <= 1'b0;
      if (capture) shreg <= {shreg[13:0], DOUT};
      if (state == ST_DONE) begin
        // A new result wins over a same-cycle consume.
        sample       <= shreg[13:2];
        sample_valid <= 1'b1;
        if (sample_valid && !sample_ready) overrun <= 1'b1;
        frame_err    <= shreg[14] | shreg[1] | shreg[0];
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_master.sv
// tb/tb_adc_spi_master.sv - self-checking bench for adc_spi_master
module tb_adc_spi_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        nCS, SCLK;
  logic        DOUT = 1'b0;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        overrun, frame_err, busy;

  adc_spi_master #(.CLK_DIV(2), .FRAME_BITS(16)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .nCS(nCS), .SCLK(SCLK), .DOUT(DOUT),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ADC model: bit n of the frame is driven on the n-th SCLK falling edge.
  logic        ovr_en = 1'b0;
  logic        ovr_lead = 1'b0;
  logic [11:0] ovr_data = 12'd0;
  logic [1:0]  ovr_trail = 2'd0;
  logic [11:0] adc_cnt = 12'd0;
  logic [15:0] word = 16'd0;
  int          model_falls = 0;

  always @(negedge nCS) model_falls = 0;

  always @(negedge SCLK) begin
    model_falls++;
    if (model_falls == 1) begin
      if (ovr_en) word = {ovr_lead, ovr_data, ovr_trail, 1'b0};
      else begin
        adc_cnt = adc_cnt + 12'd1;
        word = {1'b0, adc_cnt, 3'b000};
      end
    end
    if (model_falls <= 15) DOUT = word[16 - model_falls];
    else DOUT = 1'bz;
  end

  // Waveform monitor, sampled on the falling CLK edge.
  bit   mon_en = 1'b1;
  bit   frame_seen = 1'b0;
  bit   first_pending = 1'b0;
  int   falls = 0, rises = 0, cs_cyc = 0, err_pulses = 0;
  logic prev_sclk = 1'b1, prev_ncs = 1'b1;

  always @(negedge CLK) begin
    if (SCLK === 1'b0 && prev_sclk === 1'b1) begin
      falls++;
      if (mon_en && first_pending) check("sclk_first_fall_delay", cyc - cs_cyc, 2);
      first_pending = 1'b0;
    end
    if (SCLK === 1'b1 && prev_sclk === 1'b0) rises++;
    if (nCS === 1'b0 && prev_ncs === 1'b1) begin
      if (mon_en) check("ncs_fall_with_sclk_high", SCLK, 1);
      if (mon_en && frame_seen) check("sclk_falls_per_frame", falls, 16);
      frame_seen    = 1'b1;
      falls         = 0;
      rises         = 0;
      cs_cyc        = cyc;
      first_pending = 1'b1;
    end
    if (nCS === 1'b1 && prev_ncs === 1'b0 && mon_en) check("ncs_rise_at_sclk_rise14", rises, 14);
    if (frame_err === 1'b1) err_pulses++;
    prev_sclk = SCLK;
    prev_ncs  = nCS;
  end

  task automatic wait_valid(input string name);
    int n = 0;
    while (sample_valid === 1'b1 && n < 400) begin @(negedge CLK); n++; end
    while (sample_valid !== 1'b1 && n < 400) begin @(negedge CLK); n++; end
    check(name, sample_valid, 1);
  endtask

  task automatic wait_change(input logic [11:0] prev, input string name);
    int n = 0;
    while (sample === prev && n < 400) begin @(negedge CLK); n++; end
    check(name, (sample !== prev), 1);
  endtask

  task automatic wait_low_phase(input int k, input string name);
    int n = 0;
    while (!(rises == k - 1 && SCLK === 1'b0) && n < 400) begin @(negedge CLK); n++; end
    check(name, (n < 400), 1);
  endtask

  typedef struct {
    logic        lead;
    logic [11:0] data;
    logic [1:0]  trail;
    logic [11:0] exp_sample;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t1;
    vecs[0] = '{1'b1, 12'hA5C, 2'b00, 12'hA5C, 1'b1};
    vecs[1] = '{1'b0, 12'h3C1, 2'b00, 12'h3C1, 1'b0};
    vecs[2] = '{1'b0, 12'hFFF, 2'b10, 12'hFFF, 1'b1};
    vecs[3] = '{1'b0, 12'h000, 2'b01, 12'h000, 1'b1};
    vecs[4] = '{1'b0, 12'h800, 2'b00, 12'h800, 1'b0};

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_ncs", nCS, 1);
    check("rst_sclk", SCLK, 1);
    check("rst_sample", sample, 12'h000);
    check("rst_valid", sample_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);

    // Continuous conversion against the counting ADC
    RST = 1'b0;
    EN  = 1'b1;
    wait_valid("timeout_frame1");
    t1 = cyc;
    check("cont_sample1", sample, 12'h001);
    check("cont_err1", frame_err, 0);
    wait_valid("timeout_frame2");
    check("cont_sample2", sample, 12'h002);
    check("cont_period2", cyc - t1, 67);
    t1 = cyc;
    wait_valid("timeout_frame3");
    check("cont_sample3", sample, 12'h003);
    check("cont_period3", cyc - t1, 67);
    check("cont_no_frame_err", err_pulses, 0);

    // Table-driven frames with forced framing bits
    ovr_en    = 1'b1;
    ovr_lead  = vecs[0].lead;
    ovr_data  = vecs[0].data;
    ovr_trail = vecs[0].trail;
    for (int i = 0; i < 5; i++) begin
      wait_valid("timeout_vec");
      check($sformatf("vec%0d_sample", i), sample, vecs[i].exp_sample);
      check($sformatf("vec%0d_frame_err", i), frame_err, vecs[i].exp_err);
      if (i < 4) begin
        ovr_lead  = vecs[i+1].lead;
        ovr_data  = vecs[i+1].data;
        ovr_trail = vecs[i+1].trail;
      end else begin
        ovr_en = 1'b0;
      end
      @(negedge CLK);
      check($sformatf("vec%0d_err_width", i), frame_err, 0);
    end

    // Consumer stalls for three frames
    check("consume_clears_valid", sample_valid, 0);
    sample_ready = 1'b0;
    wait_change(12'h800, "timeout_stall1");
    check("stall1_sample", sample, 12'h004);
    check("stall1_overrun", overrun, 0);
    wait_change(12'h004, "timeout_stall2");
    check("stall2_overrun", overrun, 1);
    wait_change(12'h005, "timeout_stall3");
    check("stall3_sample", sample, 12'h006);
    check("stall3_valid", sample_valid, 1);
    check("stall3_overrun", overrun, 1);
    sample_ready = 1'b1;
    @(negedge CLK);
    sample_ready = 1'b0;
    check("accept_clears_valid", sample_valid, 0);
    check("overrun_sticky", overrun, 1);
    repeat (2) @(negedge CLK);
    check("overrun_still_sticky", overrun, 1);

    // Asynchronous reset during bit 7
    sample_ready = 1'b1;
    wait_low_phase(7, "timeout_k7");
    mon_en = 1'b0;
    #3 RST = 1'b1;
    #1;
    check("arst_ncs", nCS, 1);
    check("arst_sclk", SCLK, 1);
    check("arst_valid", sample_valid, 0);
    check("arst_overrun", overrun, 0);
    check("arst_busy", busy, 0);
    repeat (2) @(negedge CLK);
    frame_seen = 1'b0;
    RST = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);
    check("post_rst_cs_setup_ncs", nCS, 0);
    check("post_rst_cs_setup_sclk", SCLK, 1);
    wait_valid("timeout_post_rst");
    check("post_rst_sample", sample, 12'h008);
    check("post_rst_err", frame_err, 0);

    // EN dropped mid-frame: frame completes, then idle
    wait_low_phase(5, "timeout_k5");
    EN = 1'b0;
    wait_valid("timeout_en_drop");
    check("en_drop_sample", sample, 12'h009);
    check("en_drop_busy", busy, 0);
    repeat (5) @(negedge CLK);
    check("idle_busy", busy, 0);
    check("idle_ncs", nCS, 1);
    check("idle_sclk", SCLK, 1);
    EN = 1'b1;
    @(negedge CLK);
    check("reen_ncs_falls", nCS, 0);
    check("reen_busy", busy, 1);
    repeat (4) @(negedge CLK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
